// File: rtl/mem_access_ctrl.sv
// Load/store bus initiator: turns byte/half/word requests into aligned word accesses on a
// single-port sync memory, extracting sub-word loads and doing sub-word stores as read-modify-write.
module mem_access_ctrl #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int RD_WAIT    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_cs,
   output logic        mem_oe,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, WR = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        cs_q, cs_d;
   logic        oe_q, oe_d;
   logic        mwe_q, mwe_d;
   logic [31:0] din_q, din_d;
   logic        misaligned;

   // Bit position of the lowest bit of the addressed byte/half lane within the word.
   function automatic logic [4:0] lane_lo(input logic [1:0] size, input logic [1:0] a);
      logic [4:0] lo;
      lo = 5'd0;
      if (size == 2'd0)
         lo = BIG_ENDIAN ? (5'd24 - {a, 3'b000}) : {a, 3'b000};
      else if (size == 2'd1)
         lo = {(BIG_ENDIAN ? ~a[1] : a[1]), 4'b0000};
      return lo;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] a, input logic sgn);
      logic [31:0] sh;
      logic [31:0] r;
      sh = w >> lane_lo(size, a);
      case (size)
         2'd0:    r = {{24{sgn & sh[7]}}, sh[7:0]};
         2'd1:    r = {{16{sgn & sh[15]}}, sh[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                         input logic [1:0] a, input logic [15:0] wd);
      logic [31:0] m;
      logic [31:0] d;
      m = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      d = (size == 2'd0) ? {24'd0, wd[7:0]} : {16'd0, wd};
      return (w & ~(m << lane_lo(size, a))) | (d << lane_lo(size, a));
   endfunction

   assign misaligned = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      sgn_d       = sgn_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'd0;
      cs_d        = 1'b0;
      oe_d        = 1'b0;
      mwe_d       = 1'b0;
      din_d       = 32'd0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sgn_d   = req_signed;
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               if (misaligned) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (req_we && req_size == 2'd2) begin
                  state_d = WR;
                  ready_d = 1'b0;
                  cs_d    = 1'b1;
                  mwe_d   = 1'b1;
                  din_d   = req_wdata;
               end else begin
                  state_d = RD;
                  ready_d = 1'b0;
                  cs_d    = 1'b1;
                  oe_d    = 1'b1;
               end
            end
         end
         RD: begin
            state_d = CAP;
            cnt_d   = 4'(RD_WAIT);
         end
         CAP: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!we_q) begin
               state_d     = IDLE;
               ready_d     = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = extract(mem_dout, size_q, addr_q[1:0], sgn_q);
            end else begin
               state_d = WR;
               cs_d    = 1'b1;
               mwe_d   = 1'b1;
               din_d   = merge(mem_dout, size_q, addr_q[1:0], wdata_q);
            end
         end
         WR: begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         sgn_q       <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 16'd0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         cs_q        <= 1'b0;
         oe_q        <= 1'b0;
         mwe_q       <= 1'b0;
         din_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sgn_q       <= sgn_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         cs_q        <= cs_d;
         oe_q        <= oe_d;
         mwe_q       <= mwe_d;
         din_q       <= din_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_cs    = cs_q;
   assign mem_oe    = oe_q;
   assign mem_we    = mwe_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_din   = din_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Bus initiator that drives the single-port synchronous data memory (cs/oe/we/addr/din/dout, 32-bit, word-addressed by full aligned address, no byte enables). Sits between the CPU load/store stage and data memory.
- Converts byte/half/word load and store requests into aligned word accesses, extracting sub-word loads with sign/zero extension.
- Performs sub-word stores as read-modify-write.

Parameters:
- BIG_ENDIAN, 1, lane mapping: 1 = byte offset 0 is bits [31:24] (MIPS); 0 = byte offset 0 is bits [7:0].
- RD_WAIT, 0, extra cycles between the memory read strobe and sampling mem_dout (0..15).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on an edge with req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend sub-word loads; ignored for word and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for byte/half.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal size.
- mem_cs  out  1  memory chip select.
- mem_oe  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  aligned word address, {addr[31:2], 2'b00}.
- mem_din  out  32  write data.
- mem_dout  in  32  read data, valid after the edge that sampled cs & oe.

Behaviour:
- Reset (asynchronous): state = IDLE, wait counter = 0. All outputs 0 except req_ready = 1. Latched request and merge buffer cleared.
- Reset mid-operation abandons the access. Memory is only written in WR, so an RMW aborted before WR leaves memory unchanged.
- States: IDLE, RD, CAP, WR.
- IDLE, on acceptance:
  - Latch request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): no memory access; rsp_valid = 1 and rsp_err = 1 in the next cycle; stay IDLE.
  - Word store: go to WR.
  - All other requests: go to RD.
- RD (1 cycle):
  - mem_cs = 1, mem_oe = 1, mem_we = 0.
  - Go to CAP with counter = RD_WAIT.
- CAP:
  - mem_cs = 0.
  - While counter != 0, decrement it.
  - When counter = 0, sample mem_dout:
    - Load: register rsp_rdata = extract(mem_dout), rsp_valid = 1, go to IDLE.
    - Sub-word store: merge buffer = mem_dout with the addressed lane(s) replaced by req_wdata[7:0] or [15:0]; go to WR.
- WR (1 cycle):
  - mem_cs = 1, mem_we = 1, mem_oe = 0, mem_din = merged or full word.
  - Register rsp_valid = 1, rsp_rdata = 0; go to IDLE.
- Output rules:
  - mem_oe and mem_we are never both 1.
  - mem_cs is 0 in IDLE and CAP.
  - mem_addr holds the latched aligned address.
  - mem_din is 0 outside WR.
- Lane extraction (BIG_ENDIAN = 1), with k = addr[1:0]:
  - Byte = word[31-8k -: 8].
  - Half = addr[1] ? word[15:0] : word[31:16].
  - Result is extended per req_signed.
- Latency in cycles after the acceptance cycle (RD_WAIT = 0; each path adds RD_WAIT if it reads):
  - Load: rsp_valid in cycle 3.
  - Word store: rsp_valid in cycle 2.
  - Sub-word store: rsp_valid in cycle 4.
  - Error: rsp_valid in cycle 1.
- A new request may be accepted in the same cycle rsp_valid is high (state already IDLE).
- rsp_valid is high exactly one cycle per accepted request. Responses are in order; at most one request is outstanding.

Test Plan:
- Preload 0x100 = 0x823456F0; word load 0x100 -> one cycle of mem_cs = mem_oe = 1 with mem_addr = 0x100; rsp_rdata = 0x823456F0, rsp_err = 0, 3 cycles after acceptance.
- Sub-word loads on 0x100 = 0x823456F0:
  - lb signed 0x103 -> 0xFFFFFFF0.
  - lbu 0x100 -> 0x00000082.
  - lh signed 0x100 -> 0xFFFF8234.
  - lhu 0x102 -> 0x000056F0.
- sb 0x101 with wdata 0x000000AA -> read of 0x100, then a write of 0x82AA56F0; rsp_valid in cycle 4. A following lw 0x100 returns 0x82AA56F0.
- sw 0x102 and lh 0x101 -> rsp_err = 1 in cycle 1, mem_cs never asserted. req_size = 3 also errors.
- Reset pulsed during CAP of sh 0x102 with wdata 0x1234 -> all outputs clear asynchronously, no mem_we pulse. A subsequent lw 0x100 returns the unchanged word.
- Back-to-back sw 0x104 = 0xDEADBEEF, accepted in the cycle its predecessor's response is high, then lw 0x104 -> returns 0xDEADBEEF.
- With RD_WAIT = 2, latencies increase by 2.
